// File: rtl/apu_issue_queue.sv
// Purpose: in-order FIFO between core APU port and vector decoder, one instruction in flight.
// Latency: core req -> dec req >= 1 cycle (no bypass); dec rvalid -> core rvalid 1 cycle.
// Backpressure: core_apu_gnt low while full (registered count); head held until dec_apu_gnt.
module apu_issue_queue #(
  parameter int DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    n_reset,
  input  logic                    core_apu_req,
  output logic                    core_apu_gnt,
  input  logic [2:0][31:0]        core_apu_operands,
  input  logic [5:0]              core_apu_op,
  input  logic [14:0]             core_apu_flags_i,
  output logic                    core_apu_rvalid,
  output logic [31:0]             core_apu_result,
  output logic                    dec_apu_req,
  input  logic                    dec_apu_gnt,
  output logic [2:0][31:0]        dec_apu_operands,
  output logic [5:0]              dec_apu_op,
  output logic [14:0]             dec_apu_flags_i,
  input  logic                    dec_apu_rvalid,
  input  logic [31:0]             dec_apu_result,
  output logic [$clog2(DEPTH):0]  queue_count,
  output logic                    busy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [2:0][31:0] opnd_q  [DEPTH];
  logic [5:0]       op_q    [DEPTH];
  logic [14:0]      flags_q [DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          in_flight;

  logic push;
  logic pop;
  logic rsp_ok;

  // Grant looks only at registered occupancy, so a same-cycle pop never frees a slot early.
  assign core_apu_gnt = (count < FULL_CNT);
  assign dec_apu_req  = (count != '0) & ~in_flight;
  assign push         = core_apu_req & core_apu_gnt;
  assign pop          = dec_apu_req & dec_apu_gnt;
  // A completion with nothing outstanding is dropped outright.
  assign rsp_ok       = dec_apu_rvalid & in_flight;

  assign dec_apu_operands = opnd_q[rd_ptr];
  assign dec_apu_op       = op_q[rd_ptr];
  assign dec_apu_flags_i  = flags_q[rd_ptr];
  assign queue_count      = count;
  assign busy             = (count != '0) | in_flight | core_apu_rvalid;

  // Entry storage: write the accepted request at the tail slot.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        opnd_q[i]  <= '0;
        op_q[i]    <= '0;
        flags_q[i] <= '0;
      end
    end else if (push) begin
      opnd_q[wr_ptr]  <= core_apu_operands;
      op_q[wr_ptr]    <= core_apu_op;
      flags_q[wr_ptr] <= core_apu_flags_i;
    end
  end

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Single-outstanding tracker; registered so a completion cannot re-issue in the same cycle.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      in_flight <= 1'b0;
    end else if (pop) begin
      in_flight <= 1'b1;
    end else if (rsp_ok) begin
      in_flight <= 1'b0;
    end
  end

  // Response stage: one-cycle registered forward, result held between pulses.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      core_apu_rvalid <= 1'b0;
      core_apu_result <= '0;
    end else begin
      core_apu_rvalid <= rsp_ok;
      if (rsp_ok) core_apu_result <= dec_apu_result;
    end
  end

  // Flag completions arriving while nothing is outstanding (they are ignored).
  a_no_spurious_rvalid: assert property (
    @(posedge clk) disable iff (!n_reset) dec_apu_rvalid |-> in_flight
  ) else $warning("apu_issue_queue: dec_apu_rvalid with no instruction in flight, ignored");

endmodule

// File: tb/tb_apu_issue_queue.sv
// Purpose: self-checking bench for apu_issue_queue (DEPTH=2), vector table plus directed sequences.
// Latency: inputs driven 1ns after rising edge, outputs sampled on falling edge.
// Backpressure: scoreboards track issue order and core results independently of per-cycle checks.
module tb_apu_issue_queue;

  typedef struct {
    logic [2:0][31:0] opnd;
    logic [5:0]       op;
    logic [14:0]      flags;
  } ent_t;

  typedef struct {
    logic        req;
    logic [5:0]  op;
    logic        gnt;
    logic        rv;
    logic [31:0] res;
    logic        rv_exp;
    logic        e_gnt;
    logic        e_dreq;
    logic [1:0]  e_cnt;
    logic        e_busy;
    logic        e_crv;
  } vec_t;

  logic             clk;
  logic             n_reset;
  logic             core_apu_req;
  logic             core_apu_gnt;
  logic [2:0][31:0] core_apu_operands;
  logic [5:0]       core_apu_op;
  logic [14:0]      core_apu_flags_i;
  logic             core_apu_rvalid;
  logic [31:0]      core_apu_result;
  logic             dec_apu_req;
  logic             dec_apu_gnt;
  logic [2:0][31:0] dec_apu_operands;
  logic [5:0]       dec_apu_op;
  logic [14:0]      dec_apu_flags_i;
  logic             dec_apu_rvalid;
  logic [31:0]      dec_apu_result;
  logic [1:0]       queue_count;
  logic             busy;

  int n_checks = 0;
  int n_pass   = 0;
  int rv_cnt   = 0;

  ent_t        exp_iss[$];
  logic [31:0] exp_res[$];
  vec_t        tbl[17];

  apu_issue_queue #(.DEPTH(2)) dut (
    .clk               (clk),
    .n_reset           (n_reset),
    .core_apu_req      (core_apu_req),
    .core_apu_gnt      (core_apu_gnt),
    .core_apu_operands (core_apu_operands),
    .core_apu_op       (core_apu_op),
    .core_apu_flags_i  (core_apu_flags_i),
    .core_apu_rvalid   (core_apu_rvalid),
    .core_apu_result   (core_apu_result),
    .dec_apu_req       (dec_apu_req),
    .dec_apu_gnt       (dec_apu_gnt),
    .dec_apu_operands  (dec_apu_operands),
    .dec_apu_op        (dec_apu_op),
    .dec_apu_flags_i   (dec_apu_flags_i),
    .dec_apu_rvalid    (dec_apu_rvalid),
    .dec_apu_result    (dec_apu_result),
    .queue_count       (queue_count),
    .busy              (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic fail_now(input string name, input logic [127:0] act);
    n_checks++;
    $display("FAIL %s: got %0h, expected nothing", name, act);
  endtask

  function automatic ent_t mkent(input int op);
    ent_t e;
    e.opnd[0] = 32'hA000_0000 | 32'(op);
    e.opnd[1] = 32'hB000_0000 | 32'(op);
    e.opnd[2] = (32'(op) << 12) | 32'h0000_0057;
    e.op      = 6'(op);
    e.flags   = 15'(op * 3 + 1);
    return e;
  endfunction

  function automatic vec_t mk(input int req, input int op, input int gnt, input int rv,
                              input int res, input int rv_exp, input int e_gnt,
                              input int e_dreq, input int e_cnt, input int e_busy,
                              input int e_crv);
    vec_t v;
    v.req = 1'(req);     v.op = 6'(op);         v.gnt = 1'(gnt);
    v.rv = 1'(rv);       v.res = 32'(res);      v.rv_exp = 1'(rv_exp);
    v.e_gnt = 1'(e_gnt); v.e_dreq = 1'(e_dreq); v.e_cnt = 2'(e_cnt);
    v.e_busy = 1'(e_busy); v.e_crv = 1'(e_crv);
    return v;
  endfunction

  task automatic drive_req(input logic r, input ent_t e);
    core_apu_req      = r;
    core_apu_operands = e.opnd;
    core_apu_op       = e.op;
    core_apu_flags_i  = e.flags;
  endtask

  task automatic idle_inputs();
    drive_req(1'b0, mkent(0));
    dec_apu_gnt    = 1'b0;
    dec_apu_rvalid = 1'b0;
    dec_apu_result = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_gnt"},    core_apu_gnt, 1);
    check({tag, "_dreq"},   dec_apu_req, 0);
    check({tag, "_dfields"}, {dec_apu_operands, dec_apu_op, dec_apu_flags_i}, 0);
    check({tag, "_crv"},    core_apu_rvalid, 0);
    check({tag, "_cres"},   core_apu_result, 0);
    check({tag, "_count"},  queue_count, 0);
    check({tag, "_busy"},   busy, 0);
  endtask

  // Issue scoreboard: every decoder handshake must match the oldest accepted request.
  always @(negedge clk) begin
    if (n_reset && dec_apu_req && dec_apu_gnt) begin
      if (exp_iss.size() == 0) fail_now("issue_unexpected", dec_apu_op);
      else begin
        ent_t e;
        e = exp_iss.pop_front();
        check("issue_op", dec_apu_op, e.op);
        check("issue_operands", dec_apu_operands, e.opnd);
        check("issue_flags", dec_apu_flags_i, e.flags);
      end
    end
  end

  // Result scoreboard: every core rvalid pulse must carry the next expected result.
  always @(negedge clk) begin
    if (core_apu_rvalid) begin
      rv_cnt++;
      if (exp_res.size() == 0) fail_now("rvalid_unexpected", core_apu_result);
      else check("core_result", core_apu_result, exp_res.pop_front());
    end
  end

  initial begin
    ent_t e;
    int   got0;
    int   sent;
    int   issued;
    int   dly;
    bit   outst;

    // Cycle vectors: fill/backpressure, in-flight blocking, push+pop at count 1, spurious rvalid.
    tbl[0]  = mk(1, 1, 0, 0, 0,     0, 1, 0, 0, 0, 0);
    tbl[1]  = mk(1, 2, 0, 0, 0,     0, 1, 1, 1, 1, 0);
    tbl[2]  = mk(1, 3, 0, 0, 0,     0, 0, 1, 2, 1, 0);
    tbl[3]  = mk(1, 3, 1, 0, 0,     0, 0, 1, 2, 1, 0);
    tbl[4]  = mk(1, 3, 1, 0, 0,     0, 1, 0, 1, 1, 0);
    tbl[5]  = mk(0, 0, 1, 1, 'h11,  1, 0, 0, 2, 1, 0);
    tbl[6]  = mk(0, 0, 1, 0, 0,     0, 0, 1, 2, 1, 1);
    tbl[7]  = mk(0, 0, 1, 1, 'h22,  1, 1, 0, 1, 1, 0);
    tbl[8]  = mk(0, 0, 0, 0, 0,     0, 1, 1, 1, 1, 1);
    tbl[9]  = mk(1, 4, 1, 0, 0,     0, 1, 1, 1, 1, 0);
    tbl[10] = mk(0, 0, 1, 0, 0,     0, 1, 0, 1, 1, 0);
    tbl[11] = mk(0, 0, 0, 1, 'h33,  1, 1, 0, 1, 1, 0);
    tbl[12] = mk(0, 0, 1, 0, 0,     0, 1, 1, 1, 1, 1);
    tbl[13] = mk(0, 0, 0, 1, 'h44,  1, 1, 0, 0, 1, 0);
    tbl[14] = mk(0, 0, 0, 0, 0,     0, 1, 0, 0, 1, 1);
    tbl[15] = mk(0, 0, 0, 1, 'h55,  0, 1, 0, 0, 0, 0);
    tbl[16] = mk(0, 0, 0, 0, 0,     0, 1, 0, 0, 0, 0);

    n_reset = 1'b0;
    idle_inputs();
    #2;
    check_reset_outputs("rst_hold");
    repeat (2) @(posedge clk);
    #1 n_reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("rst_release");

    for (int i = 0; i < 17; i++) begin
      @(posedge clk); #1;
      e = mkent(int'(tbl[i].op));
      drive_req(tbl[i].req, e);
      dec_apu_gnt    = tbl[i].gnt;
      dec_apu_rvalid = tbl[i].rv;
      dec_apu_result = tbl[i].res;
      if (tbl[i].req && tbl[i].e_gnt) exp_iss.push_back(e);
      if (tbl[i].rv && tbl[i].rv_exp) exp_res.push_back(tbl[i].res);
      @(negedge clk);
      check($sformatf("v%0d_gnt", i),   core_apu_gnt,    tbl[i].e_gnt);
      check($sformatf("v%0d_dreq", i),  dec_apu_req,     tbl[i].e_dreq);
      check($sformatf("v%0d_count", i), queue_count,     tbl[i].e_cnt);
      check($sformatf("v%0d_busy", i),  busy,            tbl[i].e_busy);
      check($sformatf("v%0d_crv", i),   core_apu_rvalid, tbl[i].e_crv);
    end

    // Single issue timing: push c0, issue c1, completion c4, core result c5.
    @(posedge clk); #1;
    e = mkent(6);
    e.opnd[2] = 32'h0000_7057;
    drive_req(1'b1, e);
    dec_apu_gnt = 1'b1;
    dec_apu_rvalid = 1'b0;
    exp_iss.push_back(e);
    @(negedge clk);
    check("single_c0_dreq", dec_apu_req, 0);
    @(posedge clk); #1;
    drive_req(1'b0, e);
    @(negedge clk);
    check("single_c1_dreq", dec_apu_req, 1);
    check("single_c1_instr", dec_apu_operands[2], 32'h0000_7057);
    @(posedge clk); #1;
    @(negedge clk);
    check("single_c2_dreq", dec_apu_req, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    dec_apu_rvalid = 1'b1;
    dec_apu_result = 32'd4;
    exp_res.push_back(32'd4);
    @(negedge clk);
    check("single_c4_crv", core_apu_rvalid, 0);
    @(posedge clk); #1;
    dec_apu_rvalid = 1'b0;
    dec_apu_result = 32'hDEAD_BEEF;
    @(negedge clk);
    check("single_c5_crv", core_apu_rvalid, 1);
    check("single_c5_res", core_apu_result, 32'd4);
    @(posedge clk); #1;
    @(negedge clk);
    check("single_res_hold", core_apu_result, 32'd4);

    // Ordering and wrap: five entries under random grant and completion delays.
    idle_inputs();
    got0 = rv_cnt; sent = 0; issued = 0; dly = 0; outst = 1'b0;
    for (int c = 0; c < 400 && (rv_cnt - got0) < 5; c++) begin
      @(posedge clk); #1;
      dec_apu_rvalid = 1'b0;
      if (outst) begin
        if (dly == 0) begin
          dec_apu_rvalid = 1'b1;
          dec_apu_result = 32'h100 + 32'(issued);
          exp_res.push_back(32'h100 + 32'(issued));
          outst = 1'b0;
        end else dly--;
      end
      dec_apu_gnt = 1'($urandom_range(0, 1));
      e = mkent(sent + 1);
      drive_req(sent < 5, e);
      @(negedge clk);
      if (core_apu_req && core_apu_gnt) begin
        exp_iss.push_back(e);
        sent++;
      end
      if (dec_apu_req && dec_apu_gnt) begin
        outst = 1'b1;
        issued++;
        dly = int'($urandom_range(0, 3));
      end
    end
    check("wrap_rvalid_pulses", rv_cnt - got0, 5);
    check("wrap_issued", issued, 5);

    // Reset while one instruction is in flight and two are queued.
    idle_inputs();
    @(posedge clk); #1;
    e = mkent(7); drive_req(1'b1, e); dec_apu_gnt = 1'b1; exp_iss.push_back(e);
    @(posedge clk); #1;
    e = mkent(8); drive_req(1'b1, e); exp_iss.push_back(e);
    @(posedge clk); #1;
    e = mkent(9); drive_req(1'b1, e); dec_apu_gnt = 1'b0; exp_iss.push_back(e);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    check("midflight_count", queue_count, 2);
    check("midflight_dreq", dec_apu_req, 0);
    check("midflight_busy", busy, 1);
    #2 n_reset = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    exp_iss.delete();
    exp_res.delete();
    @(posedge clk); #1;
    n_reset = 1'b1;
    dec_apu_rvalid = 1'b1;
    dec_apu_result = 32'h77;
    @(negedge clk);
    check("post_rst_count", queue_count, 0);
    @(posedge clk); #1;
    dec_apu_rvalid = 1'b0;
    @(negedge clk);
    check("post_rst_no_crv", core_apu_rvalid, 0);
    check("post_rst_busy", busy, 0);
    check("post_rst_cres", core_apu_result, 0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("sb_issue_drained", exp_iss.size(), 0);
    check("sb_result_drained", exp_res.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/apu_issue_queue.md
APU_ISSUE_QUEUE -- requirements
Module: apu_issue_queue

Interface
REQ-001 SHALL provide parameter DEPTH, default 2, number of buffered APU requests (power of two, 2..4).
REQ-002 SHALL provide port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL provide port n_reset  input  1  asynchronous active-low reset.
REQ-004 SHALL provide port core_apu_req  input  1  core request valid.
REQ-005 SHALL provide port core_apu_gnt  output  1  request accepted this cycle.
REQ-006 SHALL provide port core_apu_operands  input  3x32  operands[0], operands[1], instruction word in operands[2].
REQ-007 SHALL provide port core_apu_op  input  6  APU opcode.
REQ-008 SHALL provide port core_apu_flags_i  input  15  APU flags.
REQ-009 SHALL provide port core_apu_rvalid  output  1  result valid pulse to core.
REQ-010 SHALL provide port core_apu_result  output  32  result to core.
REQ-011 SHALL provide port dec_apu_req  output  1  request to vector decoder.
REQ-012 SHALL provide port dec_apu_gnt  input  1  decoder ready (high only in its WAIT state).
REQ-013 SHALL provide ports dec_apu_operands (output 3x32), dec_apu_op (output 6), dec_apu_flags_i (output 15): head entry fields.
REQ-014 SHALL provide port dec_apu_rvalid  input  1  decoder completion pulse.
REQ-015 SHALL provide port dec_apu_result  input  32  decoder result (vl or vs2[0]).
REQ-016 SHALL provide port queue_count  output  clog2(DEPTH)+1  entries held.
REQ-017 SHALL provide port busy  output  1  high when queue non-empty or an instruction is in flight.

Function
REQ-018 SHALL store entries in a circular FIFO with wr_ptr, rd_ptr (wrap at DEPTH) and a count register.
REQ-019 SHALL drive core_apu_gnt = (count < DEPTH), combinationally from registered count only (no dependence on same-cycle pop).
REQ-020 SHALL push {operands, op, flags} at wr_ptr when core_apu_req & core_apu_gnt; wr_ptr increments with wrap.
REQ-021 SHALL have no bypass: a pushed entry is visible on dec_apu_* no earlier than the next cycle (min core-req to dec-req latency 1 cycle).
REQ-022 SHALL drive dec_apu_req = (count != 0) & ~in_flight; dec_apu_* fields always show entry at rd_ptr.
REQ-023 SHALL pop (rd_ptr increments with wrap, in_flight set) when dec_apu_req & dec_apu_gnt.
REQ-024 SHALL clear in_flight on dec_apu_rvalid; at most one instruction outstanding at the decoder.
REQ-025 SHALL, on simultaneous push and pop, leave count unchanged and advance both pointers.
REQ-026 SHALL, on simultaneous dec_apu_rvalid and pending head, not issue the next entry until the following cycle (in_flight is registered).
REQ-027 SHALL register core_apu_rvalid <= dec_apu_rvalid and core_apu_result <= dec_apu_result (1-cycle latency); core_apu_result holds its value when rvalid is low.
REQ-028 SHALL ignore dec_apu_rvalid when in_flight is low (no core rvalid, no state change); assertion flags it in simulation.
REQ-029 SHALL ignore core_apu_req while full; core keeps fields stable until granted.
REQ-030 SHALL drive busy = (count != 0) | in_flight | core_apu_rvalid.

Reset
REQ-031 SHALL, on n_reset low (asynchronous, any cycle including mid-instruction), clear wr_ptr, rd_ptr, count, in_flight, core_apu_rvalid, core_apu_result and all entry storage to 0.
REQ-032 SHALL therefore reset outputs to core_apu_gnt=1, dec_apu_req=0, dec_apu_* fields=0, core_apu_rvalid=0, core_apu_result=0, queue_count=0, busy=0.
REQ-033 SHALL discard a reset-interrupted in-flight instruction; no rvalid is produced for it.

Verification
REQ-034 Single issue: push operands[2]=0x0000_7057 cycle 0, dec_apu_gnt=1 -> dec_apu_req=1 cycle 1, pop cycle 1; dec_apu_rvalid=1 with result=4 cycle 4 -> core_apu_rvalid=1, core_apu_result=4 cycle 5.
REQ-035 Fill: dec_apu_gnt=0, push A, B -> queue_count=2, core_apu_gnt=0; third request C held until gnt; C accepted only after pop of A.
REQ-036 Ordering/wrap: push 5 entries with op=1..5 under random gnt/rvalid delays -> decoder sees op 1,2,3,4,5 in order, core receives 5 rvalid pulses.
REQ-037 Simultaneous push/pop at count=1 -> count stays 1, head becomes new older entry.
REQ-038 Reset mid-flight: assert n_reset low while in_flight=1, count=2 -> all outputs at REQ-032 values immediately; later dec_apu_rvalid produces no core_apu_rvalid.
REQ-039 Spurious dec_apu_rvalid with in_flight=0 -> core_apu_rvalid stays 0, count unchanged.
